// File: rtl/clock_pkg.sv
// clock_pkg: shared mode encodings, mode-advance helper and default system clock rate
package clock_pkg;
  typedef enum logic [2:0] {
    MODE_RUN   = 3'd0,
    MODE_SEC   = 3'd1,
    MODE_MIN   = 3'd2,
    MODE_HOUR  = 3'd3,
    MODE_MONTH = 3'd4,
    MODE_DAY   = 3'd5,
    MODE_YEAR  = 3'd6
  } mode_t;
  localparam int CLK_HZ_DEF = 1000;
  function automatic mode_t mode_next(input mode_t m);
    return (m == MODE_YEAR) ? MODE_RUN : mode_t'(m + 3'd1);
  endfunction
endpackage

// File: rtl/time_set_controller_if.sv
// time_set_controller_if: raw buttons in, 1 Hz clock, edit mode and step requests out
interface time_set_controller_if;
  import clock_pkg::*;
  logic btn_mode_raw, btn_up_raw, btn_down_raw;
  logic clk_1Hz, btn_up, btn_down;
  mode_t mode;
  modport master (output btn_mode_raw, btn_up_raw, btn_down_raw, input clk_1Hz, mode, btn_up, btn_down);
  modport slave (input btn_mode_raw, btn_up_raw, btn_down_raw, output clk_1Hz, mode, btn_up, btn_down);
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser plus stable-count debouncer, one-cycle press on debounced 1->0
module btn_debounce #(
  parameter int DEB_CYC = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);
  localparam int CW = $clog2(DEB_CYC + 1);
  logic s1, s2, level, flip;
  logic [CW-1:0] cnt;
  assign flip = (s2 != level) && (cnt == CW'(DEB_CYC - 1));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      level <= 1'b1;
      cnt <= '0;
      press <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      cnt <= (s2 == level || flip) ? '0 : cnt + 1'b1;
      level <= flip ? s2 : level;
      press <= flip && !s2;
    end
endmodule

// File: rtl/time_set_controller.sv
// time_set_controller: 1 Hz divider, button debounce, edit-mode FSM and step-request timing
module time_set_controller import clock_pkg::*; #(
  parameter int CLK_HZ  = CLK_HZ_DEF,
  parameter int DEB_CYC = 20,
  parameter int IDLE_S  = 30
) (
  input logic clk,
  input logic rst,
  time_set_controller_if.slave bus
);
  localparam int DW = $clog2(CLK_HZ);
  localparam int IW = $clog2(IDLE_S + 1);
  localparam logic [DW-1:0] HALF = DW'(CLK_HZ / 2);
  localparam logic [DW-1:0] QTR  = DW'(CLK_HZ / 4);
  localparam logic [DW-1:0] TOP  = DW'(CLK_HZ - 1);
  logic [DW-1:0] div, div_n;
  logic [IW-1:0] idle, idle_n;
  mode_t mode, mode_n;
  logic pend_up, pend_dn, pu_raw, pd_raw, pu_n, pd_n, mode_def, mode_def_n;
  logic m_ev, u_ev, d_ev, e, win, go, tmo, step_ok, lo_n;
  logic clk_1hz_q, up_q, dn_q;
  btn_debounce #(.DEB_CYC(DEB_CYC)) u_mode (.clk, .rst, .raw(bus.btn_mode_raw), .press(m_ev));
  btn_debounce #(.DEB_CYC(DEB_CYC)) u_up   (.clk, .rst, .raw(bus.btn_up_raw),   .press(u_ev));
  btn_debounce #(.DEB_CYC(DEB_CYC)) u_down (.clk, .rst, .raw(bus.btn_down_raw), .press(d_ev));
  // e marks the cycle whose closing edge raises clk_1Hz; win is the quarter period before it
  always_comb begin
    div_n = (div == TOP) ? '0 : div + 1'b1;
    e = div == HALF - 1'b1;
    win = div >= QTR && div < HALF;
    lo_n = div_n >= QTR && div_n < HALF;
    go = (m_ev || mode_def) && !win;
    mode_def_n = (m_ev || mode_def) && win;
    tmo = e && mode != MODE_RUN && idle == IW'(IDLE_S - 1);
    mode_n = tmo ? MODE_RUN : go ? mode_next(mode) : mode;
    step_ok = mode != MODE_RUN && !m_ev;
    pu_raw = ((pend_up && !e) || (u_ev && step_ok)) && !go && !tmo;
    pd_raw = ((pend_dn && !e) || (d_ev && step_ok)) && !go && !tmo;
    pu_n = pu_raw && !pd_raw;
    pd_n = pd_raw && !pu_raw;
    idle_n = (m_ev || u_ev || d_ev || mode == MODE_RUN || tmo) ? '0 : e ? idle + 1'b1 : idle;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      div <= '0;
      idle <= '0;
      mode <= MODE_RUN;
      mode_def <= 1'b0;
      pend_up <= 1'b0;
      pend_dn <= 1'b0;
      clk_1hz_q <= 1'b0;
      up_q <= 1'b1;
      dn_q <= 1'b1;
    end else begin
      div <= div_n;
      idle <= idle_n;
      mode <= mode_n;
      mode_def <= mode_def_n;
      pend_up <= pu_n;
      pend_dn <= pd_n;
      clk_1hz_q <= div_n >= HALF;
      up_q <= !(pu_n && lo_n);
      dn_q <= !(pd_n && lo_n);
    end
  assign bus.clk_1Hz = clk_1hz_q;
  assign bus.mode = mode;
  assign bus.btn_up = up_q;
  assign bus.btn_down = dn_q;
endmodule

// File: tb/tb_time_set_controller.sv
// tb_time_set_controller: directed checks of divider, debounce, mode FSM, step timing and idle timeout
module tb_time_set_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0, n_vec = 0, n_err = 0, up_steps = 0, dn_steps = 0;
  int s0, d0, pm;
  time_set_controller_if bus();
  time_set_controller dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;
  // steps as the counters see them: request level in the cycle before each 1 Hz rise
  always @(negedge clk)
    if (!rst && cyc % 1000 == 499) begin
      if (!bus.btn_up) up_steps <= up_steps + 1;
      if (!bus.btn_down) dn_steps <= dn_steps + 1;
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic go_div(input int d);
    while (cyc % 1000 != d) @(negedge clk);
  endtask
  task automatic go_abs(input int t);
    while (cyc < t) @(negedge clk);
  endtask
  task automatic press(input logic m, input logic u, input logic d);
    bus.btn_mode_raw = !m;
    bus.btn_up_raw = !u;
    bus.btn_down_raw = !d;
    repeat (30) @(negedge clk);
    {bus.btn_mode_raw, bus.btn_up_raw, bus.btn_down_raw} = 3'b111;
    repeat (30) @(negedge clk);
  endtask
  task automatic mode_step;
    if (cyc % 1000 < 540) go_div(540);
    else go_div(0);
    press(1'b1, 1'b0, 1'b0);
  endtask
  initial begin
    logic [2:0] seq [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0};
    {bus.btn_mode_raw, bus.btn_up_raw, bus.btn_down_raw} = 3'b111;
    repeat (3) @(negedge clk);
    chk("rst_clk1hz", bus.clk_1Hz, 0);
    chk("rst_mode", bus.mode, 0);
    chk("rst_up", bus.btn_up, 1);
    chk("rst_down", bus.btn_down, 1);
    rst = 1'b0;
    go_div(499); chk("rise_pre", bus.clk_1Hz, 0);
    go_div(500); chk("rise_500", bus.clk_1Hz, 1);
    for (int i = 0; i < 7; i++) begin
      mode_step();
      chk($sformatf("mode_seq%0d", i), bus.mode, 32'(seq[i]));
    end
    bus.btn_mode_raw = 1'b0;
    repeat (10) @(negedge clk);
    bus.btn_mode_raw = 1'b1;
    repeat (40) @(negedge clk);
    chk("bounce", bus.mode, 0);
    repeat (4) mode_step();
    chk("mode_month", bus.mode, 4);
    go_div(77); press(1'b0, 1'b1, 1'b0);
    s0 = up_steps;
    go_div(249); chk("up_249", bus.btn_up, 1);
    go_div(250); chk("up_250", bus.btn_up, 0);
    go_div(499); chk("up_499", bus.btn_up, 0);
    go_div(501); chk("up_501", bus.btn_up, 1);
    go_div(600); chk("one_step", up_steps, s0 + 1);
    go_div(677); press(1'b0, 1'b1, 1'b0);
    go_div(999); chk("hi_wait", bus.btn_up, 1);
    go_div(250); chk("hi_next250", bus.btn_up, 0);
    go_div(300); press(1'b0, 1'b1, 1'b0);
    go_div(600); chk("absorbed", up_steps, s0 + 2);
    go_div(300); chk("no_repeat", bus.btn_up, 1);
    repeat (4) mode_step();
    chk("mode_sec", bus.mode, 1);
    go_div(377); press(1'b1, 1'b0, 1'b0);
    go_div(499); chk("defer_hold", bus.mode, 1);
    go_div(502); chk("defer_apply", bus.mode, 2);
    s0 = up_steps; d0 = dn_steps;
    go_div(77); press(1'b0, 1'b1, 1'b1);
    go_div(300); chk("both_up", bus.btn_up, 1);
    chk("both_down", bus.btn_down, 1);
    go_div(600); chk("both_upsteps", up_steps, s0);
    chk("both_dnsteps", dn_steps, d0);
    go_div(577); press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    pm = cyc / 1000;
    chk("mode_over_step", bus.mode, 3);
    go_div(300); chk("cancel_up", bus.btn_up, 1);
    go_div(600); chk("cancel_steps", up_steps, s0);
    go_abs((pm + 29) * 1000 + 480); press(1'b0, 1'b1, 1'b0);
    go_abs((pm + 30) * 1000 + 501); chk("idle_restart", bus.mode, 3);
    go_abs((pm + 59) * 1000 + 499); chk("idle_pre", bus.mode, 3);
    go_abs((pm + 59) * 1000 + 501); chk("idle_run", bus.mode, 0);
    mode_step();
    chk("mode_sec2", bus.mode, 1);
    go_div(77); press(1'b0, 1'b1, 1'b0);
    go_div(300); chk("pre_rst_up", bus.btn_up, 0);
    #1 rst = 1'b1;
    #1;
    chk("arst_mode", bus.mode, 0);
    chk("arst_up", bus.btn_up, 1);
    chk("arst_down", bus.btn_down, 1);
    chk("arst_clk", bus.clk_1Hz, 0);
    @(negedge clk);
    rst = 1'b0;
    go_div(300); chk("post_rst_up", bus.btn_up, 1);
    chk("post_rst_mode", bus.mode, 0);
    go_div(499); chk("post_rise_pre", bus.clk_1Hz, 0);
    go_div(500); chk("post_rise", bus.clk_1Hz, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/time_set_controller.md
Name: time_set_controller

Overview:
- Front-end sequencer for the clock/calendar counter chain.
- Runs on the fast system clock. Generates the 1 Hz counter clock, debounces the three raw push-buttons, and drives the 3-bit edit `mode` plus active-low `btn_up`/`btn_down` step requests.
- Step requests are timed so the counters sample them on exactly one 1 Hz rising edge per press.
- Returns to run mode automatically after an idle timeout.

Parameters:
- CLK_HZ, 1000, system clock frequency; sets the 1 Hz divider terminal count (CLK_HZ-1).
- DEB_CYC, 20, consecutive stable samples required to accept a button level change.
- IDLE_S, 30, whole 1 Hz periods without any accepted press before forcing RUN.

Ports:
- clk  in  1  system clock, CLK_HZ.
- rst  in  1  asynchronous, active-high reset.
- btn_mode_raw  in  1  raw mode button, active-low, asynchronous to clk.
- btn_up_raw  in  1  raw increment button, active-low, asynchronous.
- btn_down_raw  in  1  raw decrement button, active-low, asynchronous.
- clk_1Hz  out  1  counter clock, 50% duty, registered.
- mode  out  3  000 RUN, 001 SEC, 010 MIN, 011 HOUR, 100 MONTH, 101 DAY, 110 YEAR; 111 never driven.
- btn_up  out  1  active-low increment request to the counters.
- btn_down  out  1  active-low decrement request to the counters.

Behaviour:
- Reset (async, active-high). All outputs take their reset values immediately: clk_1Hz=0, mode=000, btn_up=1, btn_down=1. Divider, debounce counters, pending flags and idle counter are cleared.
- Synchronisation. Each raw button passes through a 2-flop synchroniser, then a debouncer.
  - The debounced level changes only after DEB_CYC consecutive equal samples.
  - A press event is one cycle on the debounced 1->0 transition. Release produces no event.
- Divider.
  - div counts 0..CLK_HZ-1 and wraps.
  - clk_1Hz=0 while div < CLK_HZ/2, else 1.
  - The rise occurs on the clk edge where div becomes CLK_HZ/2. Call that edge E.
- Mode FSM. A mode press advances SEC->MIN->HOUR->MONTH->DAY->YEAR->RUN->SEC. Transitions take effect on the clk after the event.
- Step requests.
  - An up/down press while mode!=RUN sets pend_up or pend_dn. Presses while mode==RUN are ignored.
  - Outputs are registered: btn_up = ~(pend_up && low phase && div >= CLK_HZ/4). btn_down is the same with pend_dn.
  - The request is therefore stable at least CLK_HZ/4 cycles before edge E.
  - On E, the pend flag clears and the output returns high within 1 clk.
  - Exactly one step is applied per press. Presses arriving during the high phase wait for the next low phase.
- Simultaneous events.
  - Up and down pending together: both are cancelled, no step.
  - Mode press and step press in the same cycle: the mode change wins and all pend flags clear.
  - Any mode change clears the pend flags.
- Pending limit. At most one pending step per direction; a second press before E is absorbed.
- Idle timeout.
  - The idle counter increments on each E while mode!=RUN.
  - Any press event clears it.
  - Reaching IDLE_S forces mode=RUN and clears the pend flags.
- Reset mid-operation: pending steps are discarded, no partial pulse, mode=RUN.
- Output stability: mode never changes within CLK_HZ/4 cycles before E. A mode event in that window is deferred until the cycle after E.

Decomposition:
- Shared package `clock_pkg`:
  - mode encodings MODE_RUN..MODE_YEAR;
  - the mode-advance function;
  - default CLK_HZ.
- One sub-module, `btn_debounce`: 2-flop synchroniser, stable counter, debounced level, press-event output. Instantiated three times.

Test Plan:
- Reset with rst=1 mid-period -> clk_1Hz=0, mode=000, btn_up=btn_down=1 in the same cycle. After release, first clk_1Hz rise at cycle 500 (CLK_HZ=1000).
- Seven clean mode presses -> mode steps 001,010,011,100,101,110,000. Pulse of 10 bounce cycles -> no change.
- mode=100, one up press at div=100 -> btn_up low from div=250 through edge E at div=500, high by div=501. Exactly one low-sampled rising edge.
- Up press at div=700 (high phase) -> btn_up stays 1 until next period's div=250. Single step only. Second press before E -> still one step.
- Up and down pressed in same cycle, mode=010 -> no pulse on either output. Mode press with up pending -> mode advances, btn_up never asserted.
- mode=011, no presses -> after 30 rising edges mode=000. A press at edge 29 -> counter restarts, still 011 at edge 30.
